// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART-side signal bundle for uart_tx_arbiter.
// master = requesters plus UART transmitter, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned ID_W   = $clog2(NREQ);
  localparam int unsigned BYTE_W = 8;

  logic [NREQ-1:0]        req;
  logic [BYTE_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   uart_start;
  logic [BYTE_W-1:0]      uart_data;
  logic                   uart_tx_busy;
  logic [ID_W-1:0]        active_id;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output req, req_data, uart_tx_busy,
    input  gnt, uart_start, uart_data, active_id, busy, timeout_err
  );

  modport slave (
    input  req, req_data, uart_tx_busy,
    output gnt, uart_start, uart_data, active_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into one UART transmitter.
// Optional WAIT_BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);
  localparam int unsigned ID_W   = $clog2(NREQ);
  localparam int unsigned BYTE_W = 8;

  if (NREQ != 4 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: NREQ must be 4 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     last_id;
  logic [ID_W-1:0]     active_q;
  logic [NREQ-1:0]     gnt_q;
  logic                start_q;
  logic [BYTE_W-1:0]   data_q;
  logic                busy_q;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_id;

  // Round-robin pick: first active request at or after last_id+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_id = last_id + ID_W'(i + 1);
      if (!win_found && bus.req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_id  <= ID_W'(NREQ - 1);
      active_q <= '0;
      gnt_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      gnt_q   <= '0;
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= ISSUE;
            active_q <= win_id;
            data_q   <= bus.req_data[BYTE_W*win_id +: BYTE_W];
            gnt_q    <= NREQ'(1) << win_id;
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (bus.uart_tx_busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Transmitter never acknowledged: abandon the frame and flag it.
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            last_id   <= active_q;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (!bus.uart_tx_busy) begin
            state   <= IDLE;
            last_id <= active_q;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.uart_start = start_q;
  assign bus.uart_data  = data_q;
  assign bus.active_id  = active_q;
  assign bus.busy       = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err = tmo_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (fixed at 4 for this revision; ID width 2).
REQ-002 Parameter TIMEOUT_CYC, default 16, cycles allowed for uart_tx_busy to rise after start.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester transmit request; held high until its gnt bit pulses.
REQ-006 req_data  input  32  packed bytes; requester i drives bits [8i+7:8i]; stable while req[i]=1.
REQ-007 gnt  output  4  one-hot, one-cycle pulse: byte of requester i accepted.
REQ-008 uart_start  output  1  one-cycle start pulse to UART transmitter.
REQ-009 uart_data  output  8  byte to UART data_in; stable from start pulse until return to IDLE.
REQ-010 uart_tx_busy  input  1  UART transmitter busy flag.
REQ-011 active_id  output  2  index of requester currently being served.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 timeout_err  output  1  sticky error flag (see Configuration).

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-015 IDLE: if req!=0, select winner by round robin starting at (last_id+1) mod 4, latch req_data byte into uart_data, latch active_id, go ISSUE; else stay.
REQ-016 ISSUE: uart_start=1 and gnt[active_id]=1 for exactly this one cycle; next state WAIT_BUSY.
REQ-017 Latency: req sampled high in IDLE at edge k -> gnt/uart_start high in the cycle following edge k.
REQ-018 WAIT_BUSY: uart_tx_busy=1 -> WAIT_DONE; else stay (timeout per REQ-026).
REQ-019 WAIT_DONE: uart_tx_busy=0 -> IDLE and last_id<=active_id; earliest re-grant is next IDLE evaluation (min 1 IDLE cycle between frames).
REQ-020 Request withdrawn (req[i] low) before IDLE sampling is not granted; req changes outside IDLE are ignored.
REQ-021 Simultaneous requests: exactly one winner per frame; no requester starved, each served within 4 frames.
REQ-022 gnt never has more than one bit set; uart_start never high outside ISSUE.
REQ-023 Round-robin pointer wrap: after last_id=3 priority starts at requester 0.

Reset
REQ-024 On rst=1 at any edge, including mid-frame: state=IDLE, gnt=0, uart_start=0, uart_data=8'h00, active_id=0, busy=0, timeout_err=0, last_id=3 (requester 0 highest priority first).
REQ-025 rst has priority over all other inputs; interrupted frame is dropped, no gnt re-issued for it.

Configuration
REQ-026 Macro UART_ARB_TIMEOUT_EN defined: counter runs in WAIT_BUSY; if uart_tx_busy stays 0 for TIMEOUT_CYC cycles, set timeout_err=1 (sticky until rst), update last_id, go IDLE.
REQ-027 Macro UART_ARB_TIMEOUT_EN undefined: no counter, WAIT_BUSY waits indefinitely, timeout_err tied to 0.

Verification
REQ-028 Single request: req=4'b0001, req_data[7:0]=8'h20; tx_busy rises 2 cycles after start, held 10 cycles -> one gnt=4'b0001 pulse, one uart_start, uart_data=8'h20, busy low after tx_busy falls.
REQ-029 All four request after reset, bytes 8'hA0..8'hA3 -> grant order 0,1,2,3, four start pulses, uart_data sequence A0,A1,A2,A3.
REQ-030 req=4'b1010 held continuously -> grants alternate 1,3,1,3; requesters 0/2 never granted.
REQ-031 rst pulsed during WAIT_DONE with req=4'b0100 pending -> all outputs reset values next cycle; after release, requester 2 granted once tx_busy=0 path restarts (IDLE).
REQ-032 With UART_ARB_TIMEOUT_EN, tx_busy tied 0 after start -> timeout_err=1 exactly TIMEOUT_CYC=16 cycles after entering WAIT_BUSY, FSM back to IDLE; without macro, FSM stays in WAIT_BUSY, timeout_err=0.
